// File: rtl/cam_capture.sv
// Camera capture front end: pairs RGB444 byte pairs from a DVP-style sensor into
// 12-bit pixels and writes one frame at a time, in raster order, to a frame buffer.
module cam_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [11:0]       frame_pixel,
  output logic              frame_we,
  output logic              frame_done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2
  } state_t;

  // One extra pointer bit so the "frame full" value is representable even
  // when 2^ADDR_W equals the frame size exactly.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PIX_TOTAL = PTR_W'(H_PIXELS * V_LINES);

  state_t            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              phase_q, phase_d;
  logic [3:0]        r_q, r_d;
  logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
  logic [11:0]       frame_pixel_q, frame_pixel_d;
  logic              frame_we_q, frame_we_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic vs_fall;
  logic vs_rise;

  assign vs_fall = vsync_q & ~cam_vsync;
  assign vs_rise = ~vsync_q & cam_vsync;

  always_comb begin
    state_d       = state_q;
    vsync_d       = cam_vsync;
    ptr_d         = ptr_q;
    phase_d       = phase_q;
    r_d           = r_q;
    frame_addr_d  = frame_addr_q;
    frame_pixel_d = frame_pixel_q;
    frame_we_d    = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (capture_en) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        // Only a fresh start-of-frame begins capture, never a frame in progress.
        if (vs_fall) begin
          state_d    = S_CAPTURE;
          ptr_d      = '0;
          phase_d    = 1'b0;
          overflow_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          // End of frame takes priority over any byte sampled in the same cycle.
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = capture_en ? S_WAIT_SOF : S_IDLE;
        end else if (cam_href) begin
          if (!phase_q) begin
            r_d     = cam_data[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (ptr_q == PIX_TOTAL) begin
              overflow_d = 1'b1;
            end else begin
              frame_we_d    = 1'b1;
              frame_addr_d  = ptr_q[ADDR_W-1:0];
              frame_pixel_d = {r_q, cam_data};
              ptr_d         = ptr_q + PTR_W'(1);
            end
          end
        end else begin
          phase_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b0;
      ptr_q         <= '0;
      phase_q       <= 1'b0;
      r_q           <= '0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      ptr_q         <= ptr_d;
      phase_q       <= phase_d;
      r_q           <= r_d;
      frame_addr_q  <= frame_addr_d;
      frame_pixel_q <= frame_pixel_d;
      frame_we_q    <= frame_we_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

  // Write port: frame_we is a single-cycle strobe with no back-pressure; the
  // buffer must accept every write, and frame_addr/frame_pixel mean something
  // only in a cycle where frame_we is high.
  assign frame_addr  = frame_addr_q;
  assign frame_pixel = frame_pixel_q;
  assign frame_we    = frame_we_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture with a 4x2 frame: vector table of whole frames plus
// hand-written sequences for mid-frame arming, disarming and reset.
module tb_cam_capture;

  localparam int H_PIXELS = 4;
  localparam int V_LINES  = 2;
  localparam int ADDR_W   = 4;
  localparam int NPIX     = H_PIXELS * V_LINES;
  localparam int W        = ADDR_W + 12;

  // clock / reset
  logic pclk = 1'b0;
  logic rst_n;
  always #5 pclk = ~pclk;

  logic              capture_en;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic [ADDR_W-1:0] frame_addr;
  logic [11:0]       frame_pixel;
  logic              frame_we;
  logic              frame_done;
  logic              overflow;
  logic [1:0]        dbg_state;

  cam_capture #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_addr(frame_addr),
    .frame_pixel(frame_pixel), .frame_we(frame_we), .frame_done(frame_done),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: each observed write is compared with the oldest expected one
  always @(negedge pclk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (frame_we) begin
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL we_unexpected: addr=%0h pix=%0h with nothing expected", frame_addr, frame_pixel);
        end else begin
          e = exp_q.pop_front();
          if ({frame_addr, frame_pixel} !== e) begin
            bad++;
            $display("FAIL write: got addr=%0h pix=%0h expected addr=%0h pix=%0h",
                     frame_addr, frame_pixel, e[W-1:12], e[11:0]);
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_width", {31'd0, done_prev}, 32'd0);
      end
      done_prev = frame_done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // driver: inputs change on the falling edge, away from the sampling edge
  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge pclk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic send_frame(input int lines, input int bpl, input bit expect_cap,
                            input bit fixed_first, input int drop_at_line);
    int ptr;
    logic [3:0] r;
    logic [7:0] d;
    ptr = 0;
    r = 4'h0;
    wr_cnt = 0;
    done_cnt = 0;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      if (l == drop_at_line) capture_en = 1'b0;
      for (int b = 0; b < bpl; b++) begin
        d = 8'($urandom_range(0, 255));
        if (fixed_first && l == 0 && b == 0) d = 8'h0A;
        if (fixed_first && l == 0 && b == 1) d = 8'hBC;
        if (b % 2 == 0) begin
          r = d[3:0];
        end else if (expect_cap && ptr < NPIX) begin
          exp_q.push_back({ADDR_W'(ptr), r, d});
          ptr++;
        end
        cyc(1'b0, 1'b1, d);
      end
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
    end
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("done_after_vsync_rise", {31'd0, frame_done}, {31'd0, expect_cap});
    cyc(1'b1, 1'b0, 8'h00);
    chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
  endtask

  typedef struct {
    int lines;
    int bpl;
    int exp_writes;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lines: 2, bpl: 8,  exp_writes: 8, exp_ovf: 1'b0};
    vecs[1] = '{lines: 2, bpl: 7,  exp_writes: 6, exp_ovf: 1'b0};
    vecs[2] = '{lines: 2, bpl: 10, exp_writes: 8, exp_ovf: 1'b1};
    vecs[3] = '{lines: 2, bpl: 8,  exp_writes: 8, exp_ovf: 1'b0};
    vecs[4] = '{lines: 1, bpl: 6,  exp_writes: 3, exp_ovf: 1'b0};

    rst_n = 1'b0;
    capture_en = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_addr", 32'(frame_addr), 32'd0);
    chk("rst_pixel", 32'(frame_pixel), 32'd0);
    chk("rst_we", {31'd0, frame_we}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // arm in the middle of an active frame: nothing may be written
    wr_cnt = 0;
    done_cnt = 0;
    for (int b = 0; b < 6; b++) begin
      if (b == 2) capture_en = 1'b1;
      cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    end
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    chk("midframe_arm_writes", 32'(wr_cnt), 32'd0);
    chk("midframe_arm_done", 32'(done_cnt), 32'd0);
    chk("midframe_arm_state", 32'(dbg_state), 32'd1);

    for (int i = 0; i < 5; i++) begin
      if (i > 0) chk("ovf_held_to_sof", {31'd0, overflow}, {31'd0, vecs[i-1].exp_ovf});
      send_frame(vecs[i].lines, vecs[i].bpl, 1'b1, (i == 0), -1);
      chk("vec_writes", 32'(wr_cnt), 32'(vecs[i].exp_writes));
      chk("vec_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      chk("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("vec_state", 32'(dbg_state), 32'd1);
    end

    // disarm mid-frame: the frame still completes, then the block goes idle
    send_frame(2, 8, 1'b1, 1'b0, 1);
    chk("drop_writes", 32'(wr_cnt), 32'd8);
    chk("drop_state_idle", 32'(dbg_state), 32'd0);
    send_frame(2, 8, 1'b0, 1'b0, -1);
    chk("idle_writes", 32'(wr_cnt), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'd0);

    // reset in the middle of a line
    capture_en = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    exp_q.push_back({ADDR_W'(0), 4'h5, 8'h67});
    exp_q.push_back({ADDR_W'(1), 4'h9, 8'hAB});
    cyc(1'b0, 1'b1, 8'hF5);
    cyc(1'b0, 1'b1, 8'h67);
    cyc(1'b0, 1'b1, 8'h39);
    cyc(1'b0, 1'b1, 8'hAB);
    cyc(1'b0, 1'b1, 8'hC4);
    @(negedge pclk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_we", {31'd0, frame_we}, 32'd0);
    chk("arst_addr", 32'(frame_addr), 32'd0);
    chk("arst_pixel", 32'(frame_pixel), 32'd0);
    chk("arst_done", {31'd0, frame_done}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    done_cnt = 0;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    send_frame(2, 8, 1'b1, 1'b1, -1);
    chk("rearm_writes", 32'(wr_cnt), 32'd8);
    chk("rearm_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_PIXELS, default 640, active pixels per line.
REQ-002 Parameter V_LINES, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, frame buffer address width; 2^ADDR_W SHALL be at least H_PIXELS*V_LINES.
REQ-004 Port pclk  input  1  single clock; all inputs sampled and all outputs launched on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset, released synchronously to pclk.
REQ-006 Port capture_en  input  1  level; 1 = capture frames continuously, 0 = stop after current frame.
REQ-007 Port cam_vsync  input  1  camera vertical sync; 1 = vertical blanking.
REQ-008 Port cam_href  input  1  camera line valid; 1 = data bytes valid.
REQ-009 Port cam_data  input  8  camera byte, RGB444 in two bytes: byte0 = {xxxx, R[3:0]}, byte1 = {G[3:0], B[3:0]}.
REQ-010 Port frame_addr  output  ADDR_W  frame buffer write address, linear, raster order from 0.
REQ-011 Port frame_pixel  output  12  write data {R, G, B}, 4 bits each, matching the VGA read-side format.
REQ-012 Port frame_we  output  1  one-cycle write strobe; frame_addr and frame_pixel valid only while 1.
REQ-013 Port frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-014 Port overflow  output  1  sticky; set when the frame carries more than H_PIXELS*V_LINES pixels.

Function
REQ-015 FSM states IDLE, WAIT_SOF, CAPTURE.
REQ-016 IDLE -> WAIT_SOF when capture_en = 1; IDLE ignores all camera activity.
REQ-017 WAIT_SOF -> CAPTURE on cam_vsync falling edge (registered vsync = 1, current cam_vsync = 0); in that cycle: write pointer <- 0, byte phase <- 0, overflow <- 0.
REQ-018 Arming mid-frame SHALL NOT capture a partial frame; capture starts at the next falling edge of cam_vsync.
REQ-019 CAPTURE, cam_href = 1, phase 0: latch cam_data[3:0] as R, phase <- 1, no write.
REQ-020 CAPTURE, cam_href = 1, phase 1: pixel = {R latch, cam_data[7:0]}, phase <- 0; next cycle frame_we = 1 with frame_addr = write pointer and frame_pixel = pixel (latency 1 cycle after byte1 sampled); pointer then +1.
REQ-021 cam_href = 0: phase <- 0; an unpaired trailing byte is discarded, no write.
REQ-022 When pointer = H_PIXELS*V_LINES, further pixels are dropped (frame_we stays 0, pointer holds) and overflow <- 1; no address wrap-around.
REQ-023 CAPTURE, cam_vsync rising edge: frame_done = 1 for exactly the next cycle; next state WAIT_SOF if capture_en = 1, else IDLE; a pending phase-1 byte is discarded.
REQ-024 capture_en deasserted during CAPTURE: current frame completes normally, including frame_done.
REQ-025 cam_vsync rising edge coinciding with a phase-1 byte: vsync wins, no write for that byte.
REQ-026 frame_we and frame_done SHALL never be asserted outside CAPTURE or the cycle immediately after leaving it.

Reset
REQ-027 rst_n = 0: state IDLE; frame_addr = 0, frame_pixel = 0, frame_we = 0, frame_done = 0, overflow = 0; pointer, phase, R latch = 0.
REQ-028 Registered vsync copy resets to 0 so no falling edge is detected at reset release; reset mid-frame abandons the frame without frame_done.

Verification (bench parameters H_PIXELS = 4, V_LINES = 2)
REQ-029 Arm, vsync 1->0, 2 lines of href with 8 bytes 0x0A,0xBC,... -> 8 writes, addr 0..7, first pixel 0xABC, frame_done 1 cycle after vsync rises, overflow 0.
REQ-030 Arm while cam_vsync = 0 mid-frame -> no writes until next vsync falling edge, then addr starts at 0.
REQ-031 Line with 7 bytes (odd) -> 3 writes for that line, 7th byte discarded, next line starts at phase 0.
REQ-032 Frame with 10 pixels -> 8 writes, addr max 7, overflow = 1 and held until next SOF, where it clears.
REQ-033 Drop capture_en mid-frame -> frame completes, frame_done pulses, state IDLE, next frame ignored.
REQ-034 Assert rst_n = 0 mid-line -> all outputs 0 asynchronously, no frame_done; after release and re-arm, capture restarts at addr 0.
